// File: rtl/router_pkg.sv
// Shared router types for the input unit receive path.
//   flit_t      : one link flit, 2-bit flit_type followed by the payload
//   GSTATE_t    : per-packet state (idle / routing / active)
//   RX_STATE_t  : link-side handshake state
// Helper functions classify flit types as packet openers / closers.
package router_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    FLIT_HEAD     = 2'd0,
    FLIT_BODY     = 2'd1,
    FLIT_TAIL     = 2'd2,
    FLIT_HEADTAIL = 2'd3
  } flit_type_t;

  typedef struct packed {
    flit_type_t        flit_type;
    logic [DATA_W-1:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    G_IDLE    = 2'd0,
    G_ROUTING = 2'd1,
    G_ACTIVE  = 2'd2
  } GSTATE_t;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_ACK      = 2'd1,
    RX_WAIT_LOW = 2'd2
  } RX_STATE_t;

  // HEAD and HEADTAIL open a packet
  function automatic logic is_head(input flit_type_t t);
    return (t == FLIT_HEAD) || (t == FLIT_HEADTAIL);
  endfunction

  // TAIL and HEADTAIL close a packet
  function automatic logic is_tail(input flit_type_t t);
    return (t == FLIT_TAIL) || (t == FLIT_HEADTAIL);
  endfunction

endpackage

// File: rtl/input_unit_rx_flit_fifo.sv
// flit_fifo: DEPTH-entry flit buffer with combinational head read.
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset
//   push, wr_data     : write request and flit (ignored when full)
//   pop               : remove head (ignored when empty)
//   rd_data           : current head flit, '0 when empty
//   full, empty, count: occupancy status
module flit_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  flit_t            wr_data,
  input  logic             pop,
  output flit_t            rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  flit_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not cleared: a flush only needs the pointers and count reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/input_unit_rx.sv
// input_unit_rx: receive side of an inter-router link.
// Accepts flits through a four-phase req/ack handshake into a flit_fifo,
// tracks per-packet state, and offers the FIFO head to the switch allocator.
// Ports:
//   clk, reset_n     : clock, synchronous active-low reset
//   i_upstream_req   : upstream flit valid (held until ack seen)
//   i_flit           : incoming flit
//   o_upstream_ack   : registered one-cycle acceptance pulse
//   o_sa_req         : head available and packet not idle
//   i_sa_grant       : switch grant, pops the head when o_sa_req is high
//   o_flit           : FIFO head ('0 when empty)
//   o_gstate         : packet state
//   o_count, o_full  : FIFO occupancy
//   o_proto_err      : sticky flit-order error
// Optional: define ROUTER_IU_STATS_EN to add saturating o_flit_cnt / o_pkt_cnt.
module input_unit_rx
  import router_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_upstream_req,
  input  flit_t            i_flit,
  output logic             o_upstream_ack,
  output logic             o_sa_req,
  input  logic             i_sa_grant,
  output flit_t            o_flit,
  output GSTATE_t          o_gstate,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_proto_err
`ifdef ROUTER_IU_STATS_EN
  ,
  output logic [15:0]      o_flit_cnt,
  output logic [15:0]      o_pkt_cnt
`endif
);

  RX_STATE_t rx_state_q, rx_state_d;
  GSTATE_t   gstate_q, gstate_d;
  logic      ack_q, ack_d;
  logic      pkt_started_q, pkt_started_d;
  logic      proto_err_q, proto_err_d;

  logic      fifo_push, fifo_pop, fifo_full, fifo_empty;
  flit_t     head;

  // Full is the registered occupancy, so a same-cycle pop cannot free a slot
  assign fifo_push = (rx_state_q == RX_IDLE) && i_upstream_req && !fifo_full;
  assign o_sa_req  = !fifo_empty && (gstate_q != G_IDLE);
  assign fifo_pop  = i_sa_grant && o_sa_req;

  flit_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wr_data (i_flit),
    .pop     (fifo_pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (o_count)
  );

  assign o_flit         = head;
  assign o_full         = fifo_full;
  assign o_upstream_ack = ack_q;
  assign o_gstate       = gstate_q;
  assign o_proto_err    = proto_err_q;

  // Link handshake: capture once, pulse ack, then wait for req to drop
  always_comb begin
    rx_state_d = rx_state_q;
    ack_d      = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (fifo_push) begin
          ack_d      = 1'b1;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK:      rx_state_d = RX_WAIT_LOW;
      RX_WAIT_LOW: if (!i_upstream_req) rx_state_d = RX_IDLE;
      default:     rx_state_d = RX_IDLE;
    endcase
  end

  // Packet tracking. pkt_started marks that the opening flit has left the
  // FIFO, so a HEAD seen afterwards in the same packet is an ordering error.
  // A misplaced BODY/TAIL at an idle head still opens a packet so it is
  // forwarded rather than stuck in the FIFO.
  always_comb begin
    gstate_d      = gstate_q;
    pkt_started_d = pkt_started_q;
    proto_err_d   = proto_err_q;
    case (gstate_q)
      G_IDLE: begin
        pkt_started_d = 1'b0;
        if (!fifo_empty) begin
          gstate_d = G_ROUTING;
          if (!is_head(head.flit_type)) proto_err_d = 1'b1;
        end
      end
      G_ROUTING, G_ACTIVE: begin
        if (gstate_q == G_ROUTING) gstate_d = G_ACTIVE;
        if (gstate_q == G_ACTIVE && pkt_started_q && !fifo_empty &&
            head.flit_type == FLIT_HEAD) proto_err_d = 1'b1;
        if (fifo_pop) begin
          if (is_tail(head.flit_type)) begin
            gstate_d      = G_IDLE;
            pkt_started_d = 1'b0;
          end else begin
            pkt_started_d = 1'b1;
          end
        end
      end
      default: gstate_d = G_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state_q    <= RX_IDLE;
      ack_q         <= 1'b0;
      gstate_q      <= G_IDLE;
      pkt_started_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      ack_q         <= ack_d;
      gstate_q      <= gstate_d;
      pkt_started_q <= pkt_started_d;
      proto_err_q   <= proto_err_d;
    end
  end

`ifdef ROUTER_IU_STATS_EN
  logic [15:0] flit_cnt_q, flit_cnt_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    flit_cnt_d = flit_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (fifo_push && flit_cnt_q != 16'hFFFF) flit_cnt_d = flit_cnt_q + 16'd1;
    if (fifo_pop && is_tail(head.flit_type) && pkt_cnt_q != 16'hFFFF)
      pkt_cnt_d = pkt_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      flit_cnt_q <= flit_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign o_flit_cnt = flit_cnt_q;
  assign o_pkt_cnt  = pkt_cnt_q;
`endif

endmodule
